alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised, registered successor to the 32-bit combinational MIPS ALU.
//  - Adds valid/ready handshakes on input and output, and registered result/flags.
//  - Adds signed-overflow detection and an optional multi-cycle unsigned multiply.
//  - Sits between the ID/EX operand latch and EX/MEM; stalls the pipe via in_ready.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; legal range >= 4.
//  CNT_W  $clog2(WIDTH+1)  localparam; multiply step-counter width.
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      operands and op are valid
//  in_ready     out  1      block accepts an op this cycle
//  a            in   WIDTH  operand A
//  b            in   WIDTH  operand B
//  alu_control  in   3      op code (see BEHAVIOUR)
//  out_valid    out  1      result/flags valid
//  out_ready    in   1      consumer takes the result this cycle
//  result       out  WIDTH  result; low half of the product for MULTU
//  hi           out  WIDTH  high half of the product for MULTU; 0 for all other ops
//  zero         out  1      result==0 (MULTU: {hi,result}==0)
//  neg          out  1      result[WIDTH-1]; forced to 0 for MULTU and SLT
//  ovf          out  1      signed overflow; ADD/SUB only, else 0
//  illegal      out  1      op code unsupported in this build
// BEHAVIOUR
//  Op codes:
//  - 000 AND, 001 OR, 010 ADD, 110 SUB.
//  - 111 SLT: signed compare; result = {0..,a<b}; correct even when a-b overflows.
//  - 011 MULTU: present only with the macro.
//  - 100, 101, and 011 without the macro: illegal. result=0, hi=0, flags=0, illegal=1.
//  Handshake:
//  - An op is accepted when in_valid & in_ready.
//  - Output is transferred when out_valid & out_ready.
//  - While out_valid & !out_ready, all outputs stay stable.
//  FSM states: IDLE, BUSY, DONE.
//  - IDLE: in_ready=1.
//    - Accepting a single-cycle op: registers the outputs and goes to DONE.
//    - Accepting MULTU: loads the multiplier and goes to BUSY.
//  - BUSY: in_ready=0.
//    - One shift-add step per cycle, counter runs 0..WIDTH-1.
//    - After the WIDTH-th step: registers {hi,result} and goes to DONE.
//  - DONE: out_valid=1; in_ready=out_ready. On transfer:
//    - a simultaneous accept is handled exactly as from IDLE (back-to-back, 1 op/cycle);
//    - with no accept, goes to IDLE.
//  Latency: single-cycle ops 1 cycle (accept edge -> out_valid); MULTU WIDTH+1 cycles.
//  Arithmetic:
//  - ADD/SUB wrap modulo 2^WIDTH.
//  - ovf = operand sign bits equal (SUB: a vs ~b) and result sign differs.
//  Reset (async assert, synchronous de-assert by the system):
//  - state=IDLE; result, hi, zero, neg, ovf, illegal, out_valid = 0.
//  - Any in-flight MULTU is discarded and no output is produced for it.
//  - in_ready=1 on the first edge after release.
//  - in_valid while !in_ready is ignored; sources hold their data.
// CONFIGURATION
//  ALU_SEQ_MULTU_EN defined:
//  - 011 = MULTU, the BUSY state exists, hi is driven.
//  ALU_SEQ_MULTU_EN undefined:
//  - 011 is illegal; the BUSY state and multiplier are removed; hi tied to 0.
//  - Every op has 1-cycle latency.
// STRUCTURE
//  alu_pkg holds:
//  - localparam op codes: OP_AND, OP_OR, OP_ADD, OP_MULTU, OP_SUB, OP_SLT;
//  - state encodings: ST_IDLE, ST_BUSY, ST_DONE.
//  Sub-module alu_seq_mul:
//  - iterative unsigned shift-add multiplier with start/busy/done, parametrised by WIDTH;
//  - instantiated only under ALU_SEQ_MULTU_EN.
//  Combinational add/logic/SLT datapath is inline in alu_seq.
// TESTING  (WIDTH=32 unless stated)
//  - ADD 0x7FFFFFFF+1, out_ready=1 -> 1 cycle later result=0x80000000, ovf=1, neg=1, zero=0.
//  - SUB 5-5 then SLT 0x80000000<1 back-to-back -> result 0/zero=1, then result 1, neg=0; in_ready held 1.
//  - MULTU 0xFFFFFFFF*0xFFFFFFFF (macro on) -> in_ready=0 for 32 cycles, then hi=0xFFFFFFFE, result=1, zero=0.
//  - Op 100 -> result=0, illegal=1; op 011 with macro off -> illegal=1, 1-cycle latency.
//  - out_ready=0 for 5 cycles after AND 0xF0F0&0xFF00 -> result 0xF000 stable, in_ready=0; released on out_ready.
//  - rst_n low mid-MULTU (cycle 10) -> out_valid=0 immediately, no result after release; WIDTH=8 rerun 255*255=hi 0xFE, result 0x01.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and flag bundle for alu_seq.
// Optional multiply support is selected by ALU_SEQ_MULTU_EN in the users of this package.
package alu_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_SLT   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one step per cycle for WIDTH cycles after start.
// done marks the cycle of the last step; prod_hi/prod_lo then carry the final product.
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   add;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    // lo_q holds the unconsumed multiplier bits, shifted out LSB first
    add     = lo_q[0] ? ({1'b0, hi_q} + {1'b0, mcand_q}) : {1'b0, hi_q};
    step_hi = add[WIDTH:1];
    step_lo = {add[0], lo_q[WIDTH-1:1]};
    done    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start) begin
      mcand_d = a;
      hi_d    = '0;
      lo_d    = b;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      hi_d    = step_hi;
      lo_d    = step_lo;
      cnt_d   = cnt_q + CNT_W'(1);
      busy_d  = !done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign prod_hi = step_hi;
  assign prod_lo = step_lo;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes; MULTU exists only with ALU_SEQ_MULTU_EN.
// Latency 1 cycle (MULTU WIDTH+1); outputs hold and in_ready drops while out_valid & !out_ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  flags_t           flags_q, flags_d;

  logic             accept;
  logic             is_sub, is_mul, slt;
  logic [WIDTH-1:0] b_eff, sum, alu_res;
  flags_t           alu_flags;

`ifdef ALU_SEQ_MULTU_EN
  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  assign is_mul    = (alu_control == OP_MULTU);
  assign mul_start = accept && is_mul;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .prod_hi (mul_hi),
    .prod_lo (mul_lo)
  );
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    is_sub    = (alu_control == OP_SUB);
    b_eff     = is_sub ? ~b : b;
    sum       = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    // signed compare directly, so a-b overflow cannot corrupt SLT
    slt       = $signed(a) < $signed(b);
    alu_res   = '0;
    alu_flags = '0;
    case (alu_control)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD, OP_SUB: begin
        alu_res       = sum;
        alu_flags.ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: alu_flags.illegal = 1'b1;
    endcase
    if (!alu_flags.illegal) begin
      alu_flags.zero = (alu_res == '0);
      alu_flags.neg  = (alu_control != OP_SLT) && alu_res[WIDTH-1];
    end
  end

  always_comb begin
    in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    accept   = in_valid && in_ready;
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    case (state_q)
      ST_DONE: if (out_ready && !in_valid) state_d = ST_IDLE;
`ifdef ALU_SEQ_MULTU_EN
      ST_BUSY: begin
        if (mul_done) begin
          result_d      = mul_lo;
          hi_d          = mul_hi;
          flags_d       = '0;
          flags_d.zero  = ({mul_hi, mul_lo} == '0);
          state_d       = ST_DONE;
        end else if (!mul_busy) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: ;
    endcase
    if (accept) begin
      if (is_mul) begin
        state_d = ST_BUSY;
      end else begin
        result_d = alu_res;
        hi_d     = '0;
        flags_d  = alu_flags;
        state_d  = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;
  assign illegal   = flags_q.illegal;

endmodule
